// File: rtl/vga_bounce_source.sv
// Pixel source for the VGA driver: white frame border, a bouncing box and a background fill.
// Box motion is applied once per frame at the start of vertical blanking.
module vga_bounce_source #(
  parameter int unsigned H_ACTIVE     = 640,
  parameter int unsigned V_ACTIVE     = 480,
  parameter int unsigned BOX_SIZE     = 32,
  parameter int unsigned STEP_X       = 2,
  parameter int unsigned STEP_Y       = 1,
  parameter logic [11:0] BOX_COLOR    = 12'hF00,
  parameter logic [11:0] BG_COLOR     = 12'h008,
  parameter logic [11:0] BORDER_COLOR = 12'hFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  HCount,
  input  logic [9:0]  VCount,
  input  logic        pause,
  output logic [11:0] RGB_out,
  output logic        frame_tick,
  output logic [7:0]  bounce_count
);

  localparam int unsigned PW = 11;
  localparam logic [PW-1:0] MAX_X    = PW'(H_ACTIVE - BOX_SIZE);
  localparam logic [PW-1:0] MAX_Y    = PW'(V_ACTIVE - BOX_SIZE);
  localparam logic [PW-1:0] STEP_XW  = PW'(STEP_X);
  localparam logic [PW-1:0] STEP_YW  = PW'(STEP_Y);
  localparam logic [PW-1:0] H_ACT_W  = PW'(H_ACTIVE);
  localparam logic [PW-1:0] V_ACT_W  = PW'(V_ACTIVE);
  localparam logic [PW-1:0] H_LAST_W = PW'(H_ACTIVE - 1);
  localparam logic [PW-1:0] V_LAST_W = PW'(V_ACTIVE - 1);
  localparam logic [PW-1:0] BOX_W    = PW'(BOX_SIZE);

  logic [9:0]  box_x_q, box_x_d, box_y_q, box_y_d;
  logic        dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [9:0]  vcount_q;
  logic [11:0] rgb_d;
  logic        tick_d;
  logic [7:0]  bounce_d;
  logic [11:0] ax_x, ax_y;
  logic [PW-1:0] h_w, v_w, bx_w, by_w;

  // One axis step: returns {bounced, new_dir, new_pos}; 11-bit math avoids wrap before compare
  function automatic logic [11:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [PW-1:0] step, input logic [PW-1:0] max);
    logic [PW-1:0] pos_w;
    logic [PW-1:0] sum;
    logic [PW-1:0] dif;
    pos_w = {1'b0, pos};
    sum   = pos_w + step;
    dif   = pos_w - step;
    if (!dir) begin
      if (sum >= max) step_axis = {1'b1, 1'b1, max[9:0]};
      else            step_axis = {1'b0, 1'b0, sum[9:0]};
    end else begin
      if (pos_w <= step) step_axis = {1'b1, 1'b0, 10'd0};
      else               step_axis = {1'b0, 1'b1, dif[9:0]};
    end
  endfunction

  always_comb begin
    tick_d   = (VCount == 10'(V_ACTIVE)) && (vcount_q != 10'(V_ACTIVE));
    ax_x     = step_axis(box_x_q, dir_x_q, STEP_XW, MAX_X);
    ax_y     = step_axis(box_y_q, dir_y_q, STEP_YW, MAX_Y);
    box_x_d  = box_x_q;
    box_y_d  = box_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    bounce_d = bounce_count;
    if (tick_d && !pause) begin
      box_x_d = ax_x[9:0];
      dir_x_d = ax_x[10];
      box_y_d = ax_y[9:0];
      dir_y_d = ax_y[10];
      if (ax_x[11] || ax_y[11]) bounce_d = bounce_count + 8'd1;
    end
  end

  // Pixel priority: blanking, border, box, background
  always_comb begin
    h_w  = {1'b0, HCount};
    v_w  = {1'b0, VCount};
    bx_w = {1'b0, box_x_q};
    by_w = {1'b0, box_y_q};
    if (h_w >= H_ACT_W || v_w >= V_ACT_W) begin
      rgb_d = 12'h000;
    end else if (h_w == 11'd0 || h_w == H_LAST_W || v_w == 11'd0 || v_w == V_LAST_W) begin
      rgb_d = BORDER_COLOR;
    end else if (h_w >= bx_w && h_w < bx_w + BOX_W && v_w >= by_w && v_w < by_w + BOX_W) begin
      rgb_d = BOX_COLOR;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      box_x_q      <= 10'd0;
      box_y_q      <= 10'd0;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      vcount_q     <= 10'd0;
      RGB_out      <= 12'h000;
      frame_tick   <= 1'b0;
      bounce_count <= 8'd0;
    end else begin
      box_x_q      <= box_x_d;
      box_y_q      <= box_y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      vcount_q     <= VCount;
      RGB_out      <= rgb_d;
      frame_tick   <= tick_d;
      bounce_count <= bounce_d;
    end
  end

endmodule

// File: tb/tb_vga_bounce_source.sv
// Directed bench for vga_bounce_source: default instance plus a square-screen instance for corner hits.
module tb_vga_bounce_source;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  HCount, VCount;
  logic        pause;
  logic [11:0] rgb, rgb_sq;
  logic        tick, tick_sq;
  logic [7:0]  bcnt, bcnt_sq;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks;

  always #5 clk = ~clk;

  vga_bounce_source u_dut (
    .clk(clk), .rst(rst), .HCount(HCount), .VCount(VCount), .pause(pause),
    .RGB_out(rgb), .frame_tick(tick), .bounce_count(bcnt)
  );

  vga_bounce_source #(.H_ACTIVE(480), .V_ACTIVE(480), .BOX_SIZE(32), .STEP_X(1), .STEP_Y(1)) u_sq (
    .clk(clk), .rst(rst), .HCount(HCount), .VCount(VCount), .pause(pause),
    .RGB_out(rgb_sq), .frame_tick(tick_sq), .bounce_count(bcnt_sq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present a pixel coordinate and wait out the one-clock output latency
  task automatic drive(input int h, input int v);
    HCount = 10'(h);
    VCount = 10'(v);
    @(posedge clk);
    #1;
  endtask

  // One frame: hold VCount in blanking for a few clocks, counting ticks of the default instance
  task automatic frames(input int n, output int nt);
    nt = 0;
    for (int f = 0; f < n; f++) begin
      HCount = 10'd0;
      VCount = 10'd480;
      for (int c = 0; c < 4; c++) begin
        @(posedge clk);
        #1;
        if (tick) nt++;
      end
      VCount = 10'd0;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; pause = 1'b0; HCount = 10'd0; VCount = 10'd0;
    #2 rst = 1'b0;
    #1;
    check("reset_rgb", 32'(rgb), 32'h000);
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_bcnt", 32'(bcnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;

    drive(10, 10);   check("box_origin", 32'(rgb), 32'hF00);
    drive(0, 100);   check("border_left", 32'(rgb), 32'hFFF);
    drive(639, 5);   check("border_right", 32'(rgb), 32'hFFF);
    drive(5, 479);   check("border_bottom", 32'(rgb), 32'hFFF);
    drive(100, 100); check("background", 32'(rgb), 32'h008);
    drive(700, 100); check("hblank", 32'(rgb), 32'h000);
    drive(100, 500); check("vblank", 32'(rgb), 32'h000);

    frames(1, ticks);
    check("one_tick_per_frame", 32'(ticks), 32'd1);
    drive(2, 1);   check("f1_box_tl", 32'(rgb), 32'hF00);
    drive(1, 1);   check("f1_left_of_box", 32'(rgb), 32'h008);
    drive(33, 32); check("f1_box_br", 32'(rgb), 32'hF00);
    drive(34, 1);  check("f1_right_of_box", 32'(rgb), 32'h008);
    drive(2, 33);  check("f1_below_box", 32'(rgb), 32'h008);

    frames(303, ticks);
    check("f304_ticks", 32'(ticks), 32'd303);
    drive(608, 304); check("f304_box_at_max", 32'(rgb), 32'hF00);
    drive(607, 304); check("f304_left_of_box", 32'(rgb), 32'h008);
    drive(639, 304); check("f304_border_over_box", 32'(rgb), 32'hFFF);
    drive(608, 303); check("f304_above_box", 32'(rgb), 32'h008);
    check("f304_bcnt", 32'(bcnt), 32'd1);

    frames(1, ticks);
    drive(606, 305); check("f305_box_back", 32'(rgb), 32'hF00);
    drive(638, 305); check("f305_right_gap", 32'(rgb), 32'h008);

    pause = 1'b1;
    frames(5, ticks);
    check("pause_ticks", 32'(ticks), 32'd5);
    drive(606, 305); check("pause_box_held", 32'(rgb), 32'hF00);
    drive(605, 305); check("pause_left_held", 32'(rgb), 32'h008);
    check("pause_bcnt", 32'(bcnt), 32'd1);
    pause = 1'b0;

    frames(1, ticks);
    drive(604, 306); check("resume_box", 32'(rgb), 32'hF00);
    drive(636, 306); check("resume_right_gap", 32'(rgb), 32'h008);

    // Square instance has seen 306 moving frames; corner lands on frame 448
    frames(141, ticks);
    check("sq447_bcnt", 32'(bcnt_sq), 32'd0);
    check("def447_bcnt", 32'(bcnt), 32'd1);
    drive(447, 447); check("sq447_box", 32'(rgb_sq), 32'hF00);
    drive(446, 447); check("sq447_left", 32'(rgb_sq), 32'h008);

    frames(1, ticks);
    check("sq448_corner_bcnt", 32'(bcnt_sq), 32'd1);
    check("def448_bcnt", 32'(bcnt), 32'd2);
    drive(448, 448); check("sq448_box", 32'(rgb_sq), 32'hF00);
    drive(447, 448); check("sq448_left", 32'(rgb_sq), 32'h008);

    frames(1, ticks);
    check("sq449_bcnt", 32'(bcnt_sq), 32'd1);
    drive(447, 447); check("sq449_box_back", 32'(rgb_sq), 32'hF00);
    drive(446, 447); check("sq449_left", 32'(rgb_sq), 32'h008);
    drive(318, 447); check("def449_box", 32'(rgb), 32'hF00);
    drive(317, 447); check("def449_left", 32'(rgb), 32'h008);
    check("def449_bcnt", 32'(bcnt), 32'd2);

    // Asynchronous reset mid-frame
    drive(318, 447);
    rst = 1'b0;
    #1;
    check("midrst_rgb", 32'(rgb), 32'h000);
    check("midrst_bcnt", 32'(bcnt), 32'd0);
    check("midrst_bcnt_sq", 32'(bcnt_sq), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(10, 10); check("postrst_box_origin", 32'(rgb), 32'hF00);
    frames(1, ticks);
    check("postrst_ticks", 32'(ticks), 32'd1);
    drive(2, 1);   check("postrst_box", 32'(rgb), 32'hF00);
    drive(1, 1);   check("postrst_left", 32'(rgb), 32'h008);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
